fa_bist_checker: RTL and testbench
==================================

// Module: fa_bist_checker
// PURPOSE
//  On-chip exhaustive tester for a 1-bit full adder (A,B,Cin -> S,Cout).
//  Drives all 8 input vectors into the adder under test and reads back S/Cout.
//  Compares each result against the expected full-adder truth table.
//  Accumulates a per-vector fail mask and an error count, then reports pass/fail.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles each vector is held before sampling (legal >= 1)
//  ERR_W          4  width of err_count (saturating)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      1-cycle run request; honoured in IDLE or DONE only
//  a_o        out  1      A input to adder under test
//  b_o        out  1      B input to adder under test
//  cin_o      out  1      Cin input to adder under test
//  s_i        in   1      S from adder under test
//  cout_i     in   1      Cout from adder under test
//  busy       out  1      run in progress
//  done       out  1      run complete; results valid; held until restart/rst
//  pass       out  1      done && err_count==0
//  err_count  out  ERR_W  mismatching vectors, saturates at 2^ERR_W-1
//  fail_vec   out  8      bit k set => vector k mismatched
//  vec_idx    out  3      current vector index, {a_o,b_o,cin_o} == vec_idx
// BEHAVIOUR
//  Reset: IDLE; every output 0, including a_o/b_o/cin_o, counters, masks, flags.
//  States: IDLE -> RUN -> DONE; DONE -> RUN on start; any state -> IDLE on rst.
//  IDLE/DONE + start: next cycle enters RUN.
//    vec_idx=0, settle count=0, busy=1, done=0.
//    err_count and fail_vec cleared in that same cycle.
//  RUN: {a_o,b_o,cin_o}=vec_idx, held constant for SETTLE_CYCLES cycles.
//    On the edge ending the last held cycle (count==SETTLE_CYCLES-1), sample s_i/cout_i.
//    exp_s = ^vec_idx; exp_cout = majority(a,b,cin).
//    Mismatch on either bit: set fail_vec[vec_idx]; err_count += 1 unless saturated.
//    On that same edge: vec_idx<7 -> vec_idx+1, count=0; vec_idx==7 -> DONE.
//  Run length: busy high exactly 8*SETTLE_CYCLES cycles.
//  SETTLE_CYCLES=1: new vector every cycle, one sample per cycle.
//  DONE: busy=0, done=1, pass=(err_count==0).
//    a_o/b_o/cin_o return to 0; vec_idx holds 7.
//    Results hold until start or rst.
//  start while in RUN is ignored; it neither restarts nor extends the run.
//  rst mid-run aborts: next cycle is IDLE with all outputs 0; partial results discarded.
//  rst has priority over start in the same cycle.
//  Inputs s_i/cout_i are sampled only at the sample edge; ignored otherwise.
// TESTING
//  Golden FA attached, SETTLE=4, start pulse ->
//    busy high 32 cycles; done=1, pass=1, err_count=0, fail_vec=8'h00.
//  Cout stuck-at-0 ->
//    fail_vec=8'hE8 (vectors 3,5,6,7); err_count=4; pass=0.
//  S inverted ->
//    fail_vec=8'hFF, err_count=8, pass=0.
//    With ERR_W=2: err_count saturates at 3, fail_vec=8'hFF.
//  SETTLE=1, golden FA ->
//    a_o/b_o/cin_o step 000..111 on consecutive cycles; done after 8 cycles; pass=1.
//  rst at vec_idx=4 -> next cycle all outputs 0, IDLE.
//    A following start gives a clean full run; pass=1.
//  start pulsed mid-run -> no effect, run completes at 8*SETTLE.
//    start in DONE -> next cycle done=0, busy=1, err_count=0, fail_vec=0.

Source files
------------

// File: rtl/fa_bist_checker.sv
// Exhaustive on-chip tester for a 1-bit full adder: walks all 8 input vectors,
// compares S/Cout against the truth table and reports a fail mask and error count.
module fa_bist_checker #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             cin_o,
   input  logic             s_i,
   input  logic             cout_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       fail_vec,
   output logic [2:0]       vec_idx
);

   localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;

   logic             start_c;
   logic             sample_c;
   logic             last_c;
   logic             exp_s_c;
   logic             exp_cout_c;
   logic             mismatch_c;
   logic [ERR_W-1:0] err_upd_c;

   // Start is only honoured outside a run; the sample edge ends each held vector.
   assign start_c    = start && (state != RUN);
   assign sample_c   = (state == RUN) && (cnt == CNT_W'(SETTLE_CYCLES - 1));
   assign last_c     = sample_c && (vec_idx == 3'd7);
   assign exp_s_c    = ^vec_idx;
   assign exp_cout_c = (vec_idx[2] & vec_idx[1]) | (vec_idx[2] & vec_idx[0]) |
                       (vec_idx[1] & vec_idx[0]);
   assign mismatch_c = (s_i != exp_s_c) || (cout_i != exp_cout_c);
   assign err_upd_c  = (mismatch_c && (err_count != {ERR_W{1'b1}})) ?
                       err_count + ERR_W'(1) : err_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_c) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // Vector sequencing, result accumulation and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         vec_idx   <= 3'd0;
         a_o       <= 1'b0;
         b_o       <= 1'b0;
         cin_o     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= 8'h00;
      end else if (start_c) begin
         cnt       <= '0;
         vec_idx   <= 3'd0;
         {a_o, b_o, cin_o} <= 3'd0;
         busy      <= 1'b1;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         fail_vec  <= 8'h00;
      end else if (sample_c) begin
         err_count <= err_upd_c;
         if (mismatch_c) begin
            fail_vec[vec_idx] <= 1'b1;
         end
         cnt <= '0;
         if (last_c) begin
            {a_o, b_o, cin_o} <= 3'd0;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_upd_c == '0);
         end else begin
            vec_idx           <= vec_idx + 3'd1;
            {a_o, b_o, cin_o} <= vec_idx + 3'd1;
         end
      end else if (state == RUN) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Scoreboard bench for fa_bist_checker: three instances (SETTLE=4/ERR_W=4,
// SETTLE=4/ERR_W=2, SETTLE=1/ERR_W=4) each driving a fault-injectable adder model.
module tb_fa_bist_checker;

   typedef struct {
      int         inst;
      logic       busy;
      logic       done;
      logic       pass;
      logic [3:0] err;
      logic [7:0] fail;
      logic [2:0] vec;
      logic [2:0] abc;
      int         blen;
      string      tag;
   } exp_t;

   logic            clk = 1'b0;
   logic [2:0]      rst;
   logic [2:0]      start;
   logic [1:0]      fault [3];
   logic [2:0]      a_w, b_w, c_w, s_w, co_w;
   logic [2:0]      busy_w, done_w, pass_w;
   logic [2:0][3:0] err_w;
   logic [2:0][7:0] fail_w;
   logic [2:0][2:0] vec_w;

   exp_t snap_q[$];
   exp_t res_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   blen [3];
   logic done_q [3];

   always #5 clk = ~clk;

   // Adder under test: fault 1 = Cout stuck-at-0, fault 2 = S inverted.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         s_w[i]  = a_w[i] ^ b_w[i] ^ c_w[i];
         co_w[i] = (a_w[i] & b_w[i]) | (a_w[i] & c_w[i]) | (b_w[i] & c_w[i]);
         if (fault[i] == 2'd1) co_w[i] = 1'b0;
         if (fault[i] == 2'd2) s_w[i] = ~s_w[i];
      end
   end

   fa_bist_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) u_dut0 (
      .clk(clk), .rst(rst[0]), .start(start[0]),
      .a_o(a_w[0]), .b_o(b_w[0]), .cin_o(c_w[0]), .s_i(s_w[0]), .cout_i(co_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .err_count(err_w[0]), .fail_vec(fail_w[0]), .vec_idx(vec_w[0])
   );

   fa_bist_checker #(.SETTLE_CYCLES(4), .ERR_W(2)) u_dut1 (
      .clk(clk), .rst(rst[1]), .start(start[1]),
      .a_o(a_w[1]), .b_o(b_w[1]), .cin_o(c_w[1]), .s_i(s_w[1]), .cout_i(co_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .err_count(err_w[1][1:0]), .fail_vec(fail_w[1]), .vec_idx(vec_w[1])
   );
   assign err_w[1][3:2] = 2'b00;

   fa_bist_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut2 (
      .clk(clk), .rst(rst[2]), .start(start[2]),
      .a_o(a_w[2]), .b_o(b_w[2]), .cin_o(c_w[2]), .s_i(s_w[2]), .cout_i(co_w[2]),
      .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
      .err_count(err_w[2]), .fail_vec(fail_w[2]), .vec_idx(vec_w[2])
   );

   function automatic void chk(string tag, string fld, int i, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s inst%0d: got %0h expected %0h", tag, fld, i, act, exp);
      end
   endfunction

   function automatic void compare_all(exp_t e);
      int i = e.inst;
      chk(e.tag, "busy", i, 32'(busy_w[i]), 32'(e.busy));
      chk(e.tag, "done", i, 32'(done_w[i]), 32'(e.done));
      chk(e.tag, "pass", i, 32'(pass_w[i]), 32'(e.pass));
      chk(e.tag, "err_count", i, 32'(err_w[i]), 32'(e.err));
      chk(e.tag, "fail_vec", i, 32'(fail_w[i]), 32'(e.fail));
      chk(e.tag, "vec_idx", i, 32'(vec_w[i]), 32'(e.vec));
      chk(e.tag, "abc", i, 32'({a_w[i], b_w[i], c_w[i]}), 32'(e.abc));
   endfunction

   // Monitor: snapshots are checked on the next falling edge; results on done rising.
   always @(negedge clk) begin
      exp_t e;
      while (snap_q.size() > 0) begin
         e = snap_q.pop_front();
         compare_all(e);
      end
      for (int i = 0; i < 3; i++) begin
         if (busy_w[i] === 1'b1) blen[i]++;
         else if (done_w[i] !== 1'b1) blen[i] = 0;
         if (done_w[i] === 1'b1 && done_q[i] !== 1'b1) begin
            if (res_q.size() == 0 || res_q[0].inst != i) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_done inst%0d: got done=1 expected no completion", i);
            end else begin
               e = res_q.pop_front();
               compare_all(e);
               chk(e.tag, "busy_len", i, 32'(blen[i]), 32'(e.blen));
            end
            blen[i] = 0;
         end
         done_q[i] = done_w[i];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(int i, logic bz, logic dn, logic ps, logic [3:0] er,
                       logic [7:0] fv, logic [2:0] vi, logic [2:0] abc, string tag);
      exp_t e;
      e.inst = i; e.busy = bz; e.done = dn; e.pass = ps; e.err = er;
      e.fail = fv; e.vec = vi; e.abc = abc; e.blen = 0; e.tag = tag;
      snap_q.push_back(e);
   endtask

   task automatic expect_result(int i, logic [3:0] er, logic [7:0] fv, logic ps,
                                int bl, string tag);
      exp_t e;
      e.inst = i; e.busy = 1'b0; e.done = 1'b1; e.pass = ps; e.err = er;
      e.fail = fv; e.vec = 3'd7; e.abc = 3'd0; e.blen = bl; e.tag = tag;
      res_q.push_back(e);
   endtask

   task automatic pulse_start(int i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic wait_done(int i);
      int n = 0;
      while (done_w[i] !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   // Full run: result expectation, first-cycle RUN snapshot, bounded wait, final snapshot.
   task automatic run(int i, logic [1:0] f, logic [3:0] er, logic [7:0] fv,
                      logic ps, int bl, string tag);
      fault[i] = f;
      expect_result(i, er, fv, ps, bl, tag);
      pulse_start(i);
      snap(i, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, {tag, "_first"});
      wait_done(i);
      snap(i, 1'b0, 1'b1, ps, er, fv, 3'd7, 3'd0, {tag, "_hold"});
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

   initial begin
      rst   = 3'b111;
      start = 3'b000;
      for (int i = 0; i < 3; i++) begin
         fault[i] = 2'd0;
         blen[i]  = 0;
         done_q[i] = 1'b0;
      end
      tick();
      tick();
      for (int i = 0; i < 3; i++) snap(i, 0, 0, 0, 4'd0, 8'h00, 3'd0, 3'd0, "reset");
      tick();
      rst = 3'b000;
      tick();

      run(0, 2'd0, 4'd0, 8'h00, 1'b1, 32, "golden_s4");
      run(0, 2'd1, 4'd4, 8'hE8, 1'b0, 32, "cout_sa0");
      run(0, 2'd2, 4'd8, 8'hFF, 1'b0, 32, "s_inv");
      run(0, 2'd0, 4'd0, 8'h00, 1'b1, 32, "restart_from_done");
      run(1, 2'd2, 4'd3, 8'hFF, 1'b0, 32, "s_inv_errw2");

      // SETTLE=1: one vector per cycle
      fault[2] = 2'd0;
      expect_result(2, 4'd0, 8'h00, 1'b1, 8, "golden_s1");
      pulse_start(2);
      for (int k = 0; k < 8; k++) begin
         snap(2, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 3'(k), 3'(k), "s1_step");
         tick();
      end
      wait_done(2);
      snap(2, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 3'd7, 3'd0, "golden_s1_hold");
      tick();

      // start mid-run must neither restart nor extend
      fault[0] = 2'd0;
      expect_result(0, 4'd0, 8'h00, 1'b1, 32, "start_mid_run");
      pulse_start(0);
      repeat (10) tick();
      pulse_start(0);
      wait_done(0);
      snap(0, 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 3'd7, 3'd0, "start_mid_run_hold");
      tick();

      // reset abort at vec_idx=4 with a partial failure already recorded
      fault[0] = 2'd1;
      pulse_start(0);
      repeat (16) tick();
      snap(0, 1'b1, 1'b0, 1'b0, 4'd1, 8'h08, 3'd4, 3'd4, "pre_abort");
      rst[0] = 1'b1;
      tick();
      snap(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, "abort");
      rst[0] = 1'b0;
      tick();
      run(0, 2'd0, 4'd0, 8'h00, 1'b1, 32, "after_abort");

      // reset wins over start from DONE
      rst[0]   = 1'b1;
      start[0] = 1'b1;
      tick();
      snap(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, "rst_over_start");
      rst[0]   = 1'b0;
      start[0] = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
